// File: rtl/baser_link_ctrl_pkg.sv
// rtl/baser_link_ctrl_pkg.sv - shared XGMII word type, link FSM states and fixed XGMII words
package baser_link_ctrl_pkg;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  ctrl;
    logic        ena;
  } xgmii64_t;

  typedef enum logic [1:0] {
    WAIT_RDY  = 2'd0,
    WAIT_LOCK = 2'd1,
    LINK_UP   = 2'd2,
    RETRAIN   = 2'd3
  } link_state_t;

  localparam xgmii64_t XGMII_IDLE = '{data: 64'h07070707_07070707, ctrl: 8'hFF, ena: 1'b1};
  localparam xgmii64_t XGMII_LF   = '{data: 64'h0100009C_0100009C, ctrl: 8'h11, ena: 1'b1};
  localparam xgmii64_t XGMII_RF   = '{data: 64'h0200009C_0200009C, ctrl: 8'h11, ena: 1'b1};

  // One 32-bit column holds a sequence ordered set carrying the given fault code in lane 3
  function automatic logic col_fault(logic [31:0] d, logic [3:0] c, logic [7:0] code);
    return (c == 4'b0001) && (d == {code, 16'h0000, 8'h9C});
  endfunction

endpackage

// File: rtl/baser_link_ctrl_if.sv
// rtl/baser_link_ctrl_if.sv - link controller signal bundle; stats ports under BASER_LINK_CTRL_STATS_EN
interface baser_link_ctrl_if;
  import baser_link_ctrl_pkg::*;

  logic        tx_rdy;
  logic        rx_rdy;
  logic        rx_sync;
  xgmii64_t    xgmii_rx;
  xgmii64_t    xgmii_tx_in;
  xgmii64_t    xgmii_tx_out;
  logic        rx_reset_req;
  logic        link_up;
  logic        rx_lf;
  logic        rx_rf;
  logic [1:0]  state;
`ifdef BASER_LINK_CTRL_STATS_EN
  logic [15:0] link_drop_cnt;
  logic [15:0] retrain_cnt;
`endif

  modport master (
    output tx_rdy, rx_rdy, rx_sync, xgmii_rx, xgmii_tx_in,
`ifdef BASER_LINK_CTRL_STATS_EN
    input  link_drop_cnt, retrain_cnt,
`endif
    input  xgmii_tx_out, rx_reset_req, link_up, rx_lf, rx_rf, state
  );

  modport slave (
    input  tx_rdy, rx_rdy, rx_sync, xgmii_rx, xgmii_tx_in,
`ifdef BASER_LINK_CTRL_STATS_EN
    output link_drop_cnt, retrain_cnt,
`endif
    output xgmii_tx_out, rx_reset_req, link_up, rx_lf, rx_rf, state
  );

endinterface

// File: rtl/xgmii_fault_det.sv
// rtl/xgmii_fault_det.sv - fault ordered-set detector for one code across both columns, with hold timer
module xgmii_fault_det
  import baser_link_ctrl_pkg::*;
#(
  parameter int          FAULT_HOLD = 128,
  parameter logic [7:0]  CODE       = 8'h01
) (
  input  logic     clk,
  input  logic     rst_n,
  input  xgmii64_t xgmii_rx,
  output logic     fault
);

  localparam int HW = $clog2(FAULT_HOLD + 1);

  logic [HW-1:0] hold_cnt;
  logic          match;

  assign match = xgmii_rx.ena &
                 (col_fault(xgmii_rx.data[31:0],  xgmii_rx.ctrl[3:0], CODE) |
                  col_fault(xgmii_rx.data[63:32], xgmii_rx.ctrl[7:4], CODE));

  // Flag drops on the last of FAULT_HOLD consecutive quiet cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
      fault    <= 1'b0;
    end else if (match) begin
      hold_cnt <= HW'(FAULT_HOLD);
      fault    <= 1'b1;
    end else if (hold_cnt != '0) begin
      hold_cnt <= hold_cnt - HW'(1);
      if (hold_cnt == HW'(1)) fault <= 1'b0;
    end
  end

endmodule

// File: rtl/baser_link_ctrl.sv
// rtl/baser_link_ctrl.sv - BASE-R link bring-up FSM, fault detection and TX override
// Optional link statistics counters enabled by BASER_LINK_CTRL_STATS_EN.
module baser_link_ctrl
  import baser_link_ctrl_pkg::*;
#(
  parameter int LOCK_TIMEOUT   = 156250,
  parameter int STABLE_CYCLES  = 1024,
  parameter int RETRAIN_CYCLES = 64,
  parameter int FAULT_HOLD     = 128
) (
  input  logic               clk_156,
  input  logic               rst_156_n,
  baser_link_ctrl_if.slave   lnk
);

  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int RW = $clog2(RETRAIN_CYCLES + 1);

  link_state_t   state_q, state_d;
  logic [TW-1:0] timeout_cnt;
  logic [SW-1:0] stable_cnt;
  logic [RW-1:0] ret_cnt;
  logic          rdy_ok;
  logic          link_up_q, link_up_d;
  logic          reset_req_q, reset_req_d;
  logic          rx_lf_q, rx_rf_q;
  xgmii64_t      tx_out_q, tx_d;

  assign rdy_ok = lnk.tx_rdy & lnk.rx_rdy;

  // Every state change starts the counters from zero
  always_ff @(posedge clk_156 or negedge rst_156_n) begin
    if (!rst_156_n) begin
      state_q     <= WAIT_RDY;
      timeout_cnt <= '0;
      stable_cnt  <= '0;
      ret_cnt     <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q) begin
        timeout_cnt <= '0;
        stable_cnt  <= '0;
        ret_cnt     <= '0;
      end else begin
        if (state_q == WAIT_LOCK) begin
          timeout_cnt <= timeout_cnt + TW'(1);
          stable_cnt  <= lnk.rx_sync ? stable_cnt + SW'(1) : '0;
        end
        if (state_q == RETRAIN) ret_cnt <= ret_cnt + RW'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q != RETRAIN && !rdy_ok) begin
      state_d = WAIT_RDY;
    end else begin
      case (state_q)
        WAIT_RDY:  state_d = WAIT_LOCK;
        WAIT_LOCK: begin
          if (stable_cnt == SW'(STABLE_CYCLES))     state_d = LINK_UP;
          else if (timeout_cnt == TW'(LOCK_TIMEOUT)) state_d = RETRAIN;
        end
        LINK_UP:   if (!lnk.rx_sync) state_d = WAIT_LOCK;
        RETRAIN:   if (ret_cnt == RW'(RETRAIN_CYCLES - 1)) state_d = WAIT_RDY;
        default:   state_d = WAIT_RDY;
      endcase
    end
  end

  // Local fault and link-down both answer with RF; remote fault alone answers with idle
  always_comb begin
    link_up_d   = (state_d == LINK_UP);
    reset_req_d = (state_d == RETRAIN);
    tx_d        = lnk.xgmii_tx_in;
    if (!link_up_q || rx_lf_q) tx_d = XGMII_RF;
    else if (rx_rf_q)          tx_d = XGMII_IDLE;
  end

  always_ff @(posedge clk_156 or negedge rst_156_n) begin
    if (!rst_156_n) begin
      link_up_q   <= 1'b0;
      reset_req_q <= 1'b0;
      tx_out_q    <= XGMII_RF;
    end else begin
      link_up_q   <= link_up_d;
      reset_req_q <= reset_req_d;
      tx_out_q    <= tx_d;
    end
  end

  xgmii_fault_det #(.FAULT_HOLD(FAULT_HOLD), .CODE(8'h01)) u_lf_det (
    .clk      (clk_156),
    .rst_n    (rst_156_n),
    .xgmii_rx (lnk.xgmii_rx),
    .fault    (rx_lf_q)
  );

  xgmii_fault_det #(.FAULT_HOLD(FAULT_HOLD), .CODE(8'h02)) u_rf_det (
    .clk      (clk_156),
    .rst_n    (rst_156_n),
    .xgmii_rx (lnk.xgmii_rx),
    .fault    (rx_rf_q)
  );

  assign lnk.state        = state_q;
  assign lnk.link_up      = link_up_q;
  assign lnk.rx_reset_req = reset_req_q;
  assign lnk.rx_lf        = rx_lf_q;
  assign lnk.rx_rf        = rx_rf_q;
  assign lnk.xgmii_tx_out = tx_out_q;

`ifdef BASER_LINK_CTRL_STATS_EN
  logic [15:0] drop_q, retrain_q;

  always_ff @(posedge clk_156 or negedge rst_156_n) begin
    if (!rst_156_n) begin
      drop_q    <= '0;
      retrain_q <= '0;
    end else begin
      if (state_q == LINK_UP && state_d == WAIT_LOCK && drop_q != 16'hFFFF)
        drop_q <= drop_q + 16'd1;
      if (state_q != RETRAIN && state_d == RETRAIN && retrain_q != 16'hFFFF)
        retrain_q <= retrain_q + 16'd1;
    end
  end

  assign lnk.link_drop_cnt = drop_q;
  assign lnk.retrain_cnt   = retrain_q;
`endif

endmodule
